ser_deserializer: RTL and testbench
===================================

Name: ser_deserializer

Overview:
- Downstream companion of the team's serializer. Takes its MSB-first 1-bit stream (ser_data/ser_data_val) and rebuilds parallel words plus a count of valid bits.
- A word closes when WIDTH bits have arrived, or when ser_data_val_i drops mid-word (partial word).
- Results go out through a valid/ready output register. The serial side cannot be stalled, so words that cannot be stored are dropped and flagged.

Parameters:
- WIDTH, 8, parallel word width; serial bit k of a burst maps to word bit WIDTH-1-k.
- MIN_BITS, 3, shortest legal burst; shorter bursts are discarded and flagged.
- MOD_W, $clog2(WIDTH)+1, width of the valid-bit count (must be able to hold WIDTH).

Ports:
- clk_i  input  1  clock, all logic on rising edge
- srst_i  input  1  synchronous active-high reset
- ser_data_i  input  1  serial data bit
- ser_data_val_i  input  1  ser_data_i valid this cycle
- deser_data_o  output  WIDTH  assembled word, MSB-first, left-aligned, unused low bits 0
- deser_data_mod_o  output  MOD_W  number of valid bits in deser_data_o (MIN_BITS..WIDTH)
- deser_data_val_o  output  1  output word valid
- deser_ready_i  input  1  consumer accepts word when val&ready
- short_err_o  output  1  one-cycle pulse: burst shorter than MIN_BITS discarded
- overflow_o  output  1  one-cycle pulse: completed word dropped, buffer full

Behaviour:
- Reset: synchronous, active-high, on clk_i. All outputs 0; FSM goes to IDLE; bit counter and shift register are cleared. Reset mid-burst discards the partial word, and nothing is emitted for it. The first valid bit after reset release starts a new word.
- FSM states:
  - IDLE: waits for ser_data_val_i=1. On that cycle, captures the bit into shift register position WIDTH-1, sets cnt=1, goes to COLLECT.
  - COLLECT, val=1, cnt<WIDTH-1: stores the bit at position WIDTH-1-cnt; cnt++.
  - COLLECT, val=1, cnt==WIDTH-1: stores the last bit and closes a full word (mod=WIDTH). Goes to IDLE; the counter wraps to 0. If val is still 1 next cycle, a new word starts with no gap.
  - COLLECT, val=0: closes a partial word with mod=cnt and goes to IDLE. If cnt<MIN_BITS, the word is discarded and short_err_o pulses on the next cycle instead.
- Latency: a closed word appears on deser_data_val_o on the cycle after the closing cycle.
  - Full word: one cycle after its last bit.
  - Partial word: one cycle after the first val=0 cycle.
- Output handshake:
  - deser_data_o and deser_data_mod_o are stable while deser_data_val_o=1 and deser_ready_i=0.
  - A transfer occurs on val&ready.
  - deser_data_val_o deasserts on the cycle after the transfer unless a new word loads on that same edge.
- Boundary conditions:
  - Closing while the buffer is empty, or while the buffered word is being accepted this cycle (val&ready): the new word loads and no overflow is flagged.
  - Closing while the buffer is full and not accepted: the new word is dropped, overflow_o pulses on the next cycle, and the buffered word is retained unchanged.
- deser_ready_i is ignored while deser_data_val_o=0. The output data bus is a don't-care while val=0, but the implementation holds the last value.
- ser_data_i is ignored when ser_data_val_i=0.

Optional Feature:
- Macro: SER_DESERIALIZER_SKID_EN.
- Defined: the output buffer is a 2-entry FIFO, so words are delivered in arrival order. overflow_o fires only when both entries are full and none is accepted. deser_data_val_o is driven from the head entry.
- Undefined: single-entry output register as described above.
- Port list identical in both builds.

Decomposition:
- Package ser_deser_pkg:
  - state enum typedef (IDLE, COLLECT)
  - default WIDTH/MIN_BITS constants
  - MOD_W helper function
  - packed struct {data, mod} used as the buffer entry type
- One sub-module, ser_deser_out_buf: the output buffer (1 or 2 entries under the macro). It has a push/entry/full interface and the valid/ready output; it generates overflow_o.
- The FSM, counter and shift register stay in ser_deserializer.

Test Plan (WIDTH=8, MIN_BITS=3):
1. Bits 1,0,1,1,0,0,1,0 on 8 consecutive val cycles, ready=1 -> data=8'hB2, mod=8, val high exactly one cycle, one cycle after the last bit.
2. Bits 1,1,0,1,1 then val=0 -> data=8'hD8, mod=5, val one cycle after val falls; no flags.
3. Bits 1,0 then val=0 -> no val pulse; short_err_o=1 for one cycle.
4. 16 continuous val cycles carrying 8'hA5 then 8'h3C, ready=1 -> two words 8'hA5 then 8'h3C, 8 cycles apart, both mod=8.
5. ready=0, two full words 8'h11 then 8'h22:
   - without the macro -> 8'h11 held, overflow_o pulse at the second close; raising ready yields only 8'h11.
   - with SER_DESERIALIZER_SKID_EN -> both delivered in order, no overflow; a third word overflows.
6. srst_i=1 for one cycle after 4 bits of a burst -> no output, no flags; the following 8-bit burst 8'hC3 is delivered correctly with mod=8.

Source files
------------

// File: rtl/ser_deser_pkg.sv
// Shared types and defaults for the serial-to-parallel deserializer.
package ser_deser_pkg;

  typedef enum logic {IDLE, COLLECT} state_t;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_MIN_BITS = 3;

  // The count must be able to hold WIDTH itself, hence the extra bit.
  function automatic int mod_w(input int width);
    return $clog2(width) + 1;
  endfunction

  localparam int DEF_MOD_W = mod_w(DEF_WIDTH);

  typedef struct packed {
    logic [DEF_WIDTH-1:0] data;
    logic [DEF_MOD_W-1:0] mod;
  } word_t;

endpackage

// File: rtl/ser_deser_out_buf.sv
// Output buffer with valid/ready handshake and overflow flag.
// SER_DESERIALIZER_SKID_EN selects a 2-entry FIFO instead of a single register.
module ser_deser_out_buf
  import ser_deser_pkg::*;
#(
  parameter type entry_t = word_t
) (
  input  logic   clk,
  input  logic   srst,
  input  logic   push,
  input  entry_t entry,
  output entry_t head,
  output logic   val,
  input  logic   ready,
  output logic   overflow
);

`ifdef SER_DESERIALIZER_SKID_EN
  entry_t     tail;
  logic [1:0] count;
  logic       pop;
  logic       full;
  logic       load;

  assign val  = (count != 2'd0);
  assign pop  = val && ready;
  assign full = (count == 2'd2) && !pop;
  assign load = push && !full;

  always_ff @(posedge clk) begin
    if (srst) begin
      // NOTE: both entries are cleared on reset so the held output is 0 afterwards.
      head     <= '0;
      tail     <= '0;
      count    <= 2'd0;
      overflow <= 1'b0;
    end else begin
      overflow <= push && full;
      case ({load, pop})
        2'b10: begin
          if (count == 2'd0) head <= entry;
          else               tail <= entry;
          count <= count + 2'd1;
        end
        2'b01: begin
          // A lone entry stays on the bus after it drains.
          if (count == 2'd2) head <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd2) begin
            head <= tail;
            tail <= entry;
          end else begin
            head <= entry;
          end
        end
        default: ;
      endcase
    end
  end
`else
  logic full;

  assign full = val && !ready;

  always_ff @(posedge clk) begin
    if (srst) begin
      // NOTE: the single entry is cleared on reset so the held output is 0 afterwards.
      head     <= '0;
      val      <= 1'b0;
      overflow <= 1'b0;
    end else begin
      overflow <= push && full;
      if (push && !full) begin
        head <= entry;
        val  <= 1'b1;
      end else if (ready) begin
        val <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: rtl/ser_deserializer.sv
// Rebuilds MSB-first serial bursts into left-aligned parallel words plus a bit count.
// SER_DESERIALIZER_SKID_EN deepens the output buffer to two entries.
module ser_deserializer
  import ser_deser_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MIN_BITS = DEF_MIN_BITS,
  parameter int MOD_W    = mod_w(WIDTH)
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             ser_data_i,
  input  logic             ser_data_val_i,
  output logic [WIDTH-1:0] deser_data_o,
  output logic [MOD_W-1:0] deser_data_mod_o,
  output logic             deser_data_val_o,
  input  logic             deser_ready_i,
  output logic             short_err_o,
  output logic             overflow_o
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [MOD_W-1:0] mod;
  } entry_t;

  state_t           state;
  logic [MOD_W-1:0] cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] bit_mask;
  logic             last_bit;
  logic             close_partial;
  logic             push;
  entry_t           entry;
  entry_t           head;

  // One-hot slot for the bit arriving this cycle: bit k lands at WIDTH-1-k.
  assign bit_mask      = {1'b1, {(WIDTH-1){1'b0}}} >> cnt;
  assign last_bit      = (state == COLLECT) && ser_data_val_i && (cnt == MOD_W'(WIDTH-1));
  assign close_partial = (state == COLLECT) && !ser_data_val_i;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    entry.data = shreg;
    entry.mod  = cnt;
    push       = 1'b0;
    if (last_bit) begin
      entry.data = shreg | ({WIDTH{ser_data_i}} & bit_mask);
      entry.mod  = MOD_W'(WIDTH);
      push       = !srst_i;
    end else if (close_partial && (cnt >= MOD_W'(MIN_BITS))) begin
      push = !srst_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      state       <= IDLE;
      cnt         <= '0;
      shreg       <= '0;
      short_err_o <= 1'b0;
    end else begin
      short_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (ser_data_val_i) begin
            shreg <= {ser_data_i, {(WIDTH-1){1'b0}}};
            cnt   <= MOD_W'(1);
            state <= COLLECT;
          end
        end
        COLLECT: begin
          if (ser_data_val_i) begin
            if (last_bit) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              shreg <= shreg | ({WIDTH{ser_data_i}} & bit_mask);
              cnt   <= cnt + MOD_W'(1);
            end
          end else begin
            cnt         <= '0;
            state       <= IDLE;
            short_err_o <= (cnt < MOD_W'(MIN_BITS));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  ser_deser_out_buf #(
    .entry_t (entry_t)
  ) u_out_buf (
    .clk      (clk_i),
    .srst     (srst_i),
    .push     (push),
    .entry    (entry),
    .head     (head),
    .val      (deser_data_val_o),
    .ready    (deser_ready_i),
    .overflow (overflow_o)
  );

  assign deser_data_o     = head.data;
  assign deser_data_mod_o = head.mod;

endmodule

// File: tb/tb_ser_deserializer.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_ser_deserializer;

  localparam int WIDTH    = 8;
  localparam int MIN_BITS = 3;
  localparam int MOD_W    = 4;
`ifdef SER_DESERIALIZER_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic             clk_i = 1'b0;
  logic             srst_i = 1'b1;
  logic             ser_data_i = 1'b0;
  logic             ser_data_val_i = 1'b0;
  logic             deser_ready_i = 1'b0;
  logic [WIDTH-1:0] deser_data_o;
  logic [MOD_W-1:0] deser_data_mod_o;
  logic             deser_data_val_o;
  logic             short_err_o;
  logic             overflow_o;

  always #5 clk_i = ~clk_i;

  ser_deserializer #(
    .WIDTH    (WIDTH),
    .MIN_BITS (MIN_BITS),
    .MOD_W    (MOD_W)
  ) dut (
    .clk_i            (clk_i),
    .srst_i           (srst_i),
    .ser_data_i       (ser_data_i),
    .ser_data_val_i   (ser_data_val_i),
    .deser_data_o     (deser_data_o),
    .deser_data_mod_o (deser_data_mod_o),
    .deser_data_val_o (deser_data_val_o),
    .deser_ready_i    (deser_ready_i),
    .short_err_o      (short_err_o),
    .overflow_o       (overflow_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: the current burst as a list of bits, the output buffer as a queue of words.
  typedef struct {
    int data;
    int mod;
  } word_m_t;

  int      burst[$];
  word_m_t outq[$];
  bit      exp_short;
  bit      exp_ovf;

  task automatic model_step(input logic v, input logic b, input logic r, input logic s);
    bit      closed;
    word_m_t w;
    exp_short = 0;
    exp_ovf   = 0;
    closed    = 0;
    if (s) begin
      burst.delete();
      outq.delete();
      return;
    end
    if (v) begin
      burst.push_back(int'(b));
      if (burst.size() == WIDTH) closed = 1;
    end else if (burst.size() > 0) begin
      if (burst.size() < MIN_BITS) exp_short = 1;
      else                         closed    = 1;
    end
    if (closed) begin
      w.data = 0;
      for (int k = 0; k < burst.size(); k++) w.data += burst[k] * (1 << (WIDTH - 1 - k));
      w.mod = burst.size();
    end
    if (closed || !v) burst.delete();
    if (outq.size() > 0 && r) void'(outq.pop_front());
    if (closed) begin
      if (outq.size() < DEPTH) outq.push_back(w);
      else                     exp_ovf = 1;
    end
  endtask

  logic [11:0] got[$];
  int          n_short = 0;
  int          n_ovf = 0;

  // Drive one cycle of inputs, advance the model at the edge, compare on the falling edge.
  task automatic step(input logic v, input logic b, input logic r, input logic s);
    ser_data_val_i = v;
    ser_data_i     = b;
    deser_ready_i  = r;
    srst_i         = s;
    if (!s && deser_data_val_o && r) got.push_back({deser_data_mod_o, deser_data_o});
    @(posedge clk_i);
    model_step(v, b, r, s);
    @(negedge clk_i);
    check("val", {31'd0, deser_data_val_o}, {31'd0, outq.size() > 0});
    check("short_err", {31'd0, short_err_o}, {31'd0, exp_short});
    check("overflow", {31'd0, overflow_o}, {31'd0, exp_ovf});
    if (outq.size() > 0) begin
      check("data", {24'd0, deser_data_o}, outq[0].data);
      check("mod", {28'd0, deser_data_mod_o}, outq[0].mod);
    end
    if (short_err_o) n_short++;
    if (overflow_o)  n_ovf++;
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, r, 1'b0);
  endtask

  task automatic send_bits(input logic [7:0] w, input int n, input logic r);
    for (int k = 0; k < n; k++) step(1'b1, w[7-k], r, 1'b0);
  endtask

  task automatic expect_word(input string tag, input int idx, input logic [11:0] exp);
    if (idx < got.size()) check(tag, {20'd0, got[idx]}, {20'd0, exp});
    else                  check(tag, 32'hFFFF_FFFF, {20'd0, exp});
  endtask

  task automatic clear_log();
    got.delete();
    n_short = 0;
    n_ovf   = 0;
  endtask

  initial begin
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("reset_data", {24'd0, deser_data_o}, 32'd0);
    check("reset_mod", {28'd0, deser_data_mod_o}, 32'd0);
    idle(2, 1'b1);

    clear_log();
    send_bits(8'hB2, 8, 1'b1);
    idle(3, 1'b1);
    check("t1_count", got.size(), 32'd1);
    expect_word("t1_word", 0, 12'h8B2);

    clear_log();
    send_bits(8'hD8, 5, 1'b1);
    idle(3, 1'b1);
    check("t2_count", got.size(), 32'd1);
    expect_word("t2_word", 0, 12'h5D8);
    check("t2_flags", n_short + n_ovf, 32'd0);

    clear_log();
    send_bits(8'h80, 2, 1'b1);
    idle(3, 1'b1);
    check("t3_count", got.size(), 32'd0);
    check("t3_short", n_short, 32'd1);

    clear_log();
    send_bits(8'hA5, 8, 1'b1);
    send_bits(8'h3C, 8, 1'b1);
    idle(3, 1'b1);
    check("t4_count", got.size(), 32'd2);
    expect_word("t4_word0", 0, 12'h8A5);
    expect_word("t4_word1", 1, 12'h83C);

    clear_log();
    send_bits(8'h11, 8, 1'b0);
    send_bits(8'h22, 8, 1'b0);
    idle(2, 1'b0);
`ifdef SER_DESERIALIZER_SKID_EN
    check("t5_ovf_two", n_ovf, 32'd0);
    send_bits(8'h33, 8, 1'b0);
    idle(2, 1'b0);
    check("t5_ovf_three", n_ovf, 32'd1);
    idle(4, 1'b1);
    check("t5_count", got.size(), 32'd2);
    expect_word("t5_word0", 0, 12'h811);
    expect_word("t5_word1", 1, 12'h822);
`else
    check("t5_ovf", n_ovf, 32'd1);
    idle(4, 1'b1);
    check("t5_count", got.size(), 32'd1);
    expect_word("t5_word0", 0, 12'h811);
`endif

    clear_log();
    send_bits(8'hF0, 4, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    send_bits(8'hC3, 8, 1'b1);
    idle(3, 1'b1);
    check("t6_count", got.size(), 32'd1);
    expect_word("t6_word", 0, 12'h8C3);
    check("t6_flags", n_short + n_ovf, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 85), 1'($urandom), ($urandom_range(0, 99) < 60),
           ($urandom_range(0, 299) == 0));
    end
    idle(4, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
